// File: rtl/flappy_pkg.sv
// flappy_pkg: game-wide types and constants shared by the pipe tracker,
// the score display and the other game blocks.
`default_nettype none

package flappy_pkg;

   localparam int ROWS      = 16;
   localparam int FLOOR_ROW = 15;
   localparam int CNT_W     = 8;
   localparam int ROW_W     = $clog2(ROWS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLEAR   = 2'd1,
      IN_PIPE = 2'd2,
      DEAD    = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_tracker.sv
// pipe_tracker: follows the bird through the pipe in its column and emits a
// one-tick pass pulse per cleared pipe, a sticky lose flag and a debug count.
`default_nettype none

module pipe_tracker
   import flappy_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             cycle,
   input  logic             start,
   input  logic [ROW_W-1:0] bird_row,
   input  logic [ROWS-1:0]  pipe_col,
   output logic             pass,
   output logic             lose,
   output logic [CNT_W-1:0] passed_cnt
);

   state_t           state_q, state_d;
   logic             pend_q, pend_d;
   logic             lose_q, lose_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit;
   logic             pipe_exit;

   assign hit = pipe_col[bird_row] | (bird_row == ROW_W'(FLOOR_ROW));

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      lose_d    = lose_q;
      cnt_d     = cnt_q;
      pipe_exit = 1'b0;

      // DEAD is terminal, so ticks are ignored there; pending pass already 0.
      if (cycle && (state_q != DEAD)) begin
         pend_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) state_d = CLEAR;
            end
            CLEAR: begin
               if (hit) begin
                  state_d = DEAD;
                  lose_d  = 1'b1;
               end else if (pipe_col != '0) begin
                  state_d = IN_PIPE;
               end
            end
            IN_PIPE: begin
               if (hit) begin
                  state_d = DEAD;
                  lose_d  = 1'b1;
               end else if (pipe_col == '0) begin
                  state_d   = CLEAR;
                  pipe_exit = 1'b1;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase

         if (pipe_exit) begin
            pend_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         lose_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         lose_q  <= lose_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pass       = pend_q;
   assign lose       = lose_q;
   assign passed_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_tracker.sv
// tb_pipe_tracker: directed scoreboard bench for pipe_tracker.
`default_nettype none

module tb_pipe_tracker;
   import flappy_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cycle;
   logic        start;
   logic [3:0]  bird_row;
   logic [15:0] pipe_col;
   logic        pass;
   logic        lose;
   logic [7:0]  passed_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic       pass;
      logic       lose;
      logic [7:0] cnt;
      state_t     st;
   } exp_t;

   exp_t sb[$];

   pipe_tracker dut (
      .clk        (clk),
      .reset      (reset),
      .cycle      (cycle),
      .start      (start),
      .bird_row   (bird_row),
      .pipe_col   (pipe_col),
      .pass       (pass),
      .lose       (lose),
      .passed_cnt (passed_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ep, input logic el,
                            input logic [7:0] ec, input state_t es);
      check({tag, ".pass"},  {7'd0, pass}, {7'd0, ep});
      check({tag, ".lose"},  {7'd0, lose}, {7'd0, el});
      check({tag, ".cnt"},   passed_cnt, ec);
      check({tag, ".state"}, {6'd0, dut.state_q}, {6'd0, es});
   endtask

   // Expected outcome is queued as the tick is driven, then popped once the
   // DUT has taken the tick edge.
   task automatic tick(input string tag, input logic st, input logic [3:0] row,
                       input logic [15:0] col, input logic ep, input logic el,
                       input logic [7:0] ec, input state_t es);
      exp_t e;
      sb.push_back('{tag, ep, el, ec, es});
      @(negedge clk);
      start    = st;
      bird_row = row;
      pipe_col = col;
      cycle    = 1'b1;
      @(negedge clk);
      cycle = 1'b0;
      e = sb.pop_front();
      check_all(e.tag, e.pass, e.lose, e.cnt, e.st);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all("reset", 1'b0, 1'b0, 8'd0, IDLE);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset    = 1'b0;
      cycle    = 1'b0;
      start    = 1'b0;
      bird_row = 4'd5;
      pipe_col = 16'h0000;
      #12;
      check_all("por", 1'b0, 1'b0, 8'd0, IDLE);
      @(negedge clk);
      reset = 1'b1;

      // Idle without start stays idle
      tick("idle_nostart", 1'b0, 4'd5, 16'h0000, 1'b0, 1'b0, 8'd0, IDLE);
      tick("start",        1'b1, 4'd5, 16'h0000, 1'b0, 1'b0, 8'd0, CLEAR);
      tick("clear_stay",   1'b0, 4'd5, 16'h0000, 1'b0, 1'b0, 8'd0, CLEAR);
      tick("enter_pipe",   1'b0, 4'd5, 16'hFC0F, 1'b0, 1'b0, 8'd0, IN_PIPE);
      tick("in_pipe_stay", 1'b0, 4'd5, 16'hFC0F, 1'b0, 1'b0, 8'd0, IN_PIPE);
      tick("exit_pipe",    1'b0, 4'd5, 16'h0000, 1'b1, 1'b0, 8'd1, CLEAR);

      // pass holds between ticks
      repeat (3) @(negedge clk);
      check_all("pass_hold", 1'b1, 1'b0, 8'd1, CLEAR);
      tick("pass_clear",   1'b0, 4'd5, 16'h0000, 1'b0, 1'b0, 8'd1, CLEAR);
      tick("enter_pipe2",  1'b0, 4'd5, 16'hFC0F, 1'b0, 1'b0, 8'd1, IN_PIPE);

      // Inputs between ticks must be ignored
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         pipe_col = 16'($urandom);
         bird_row = 4'($urandom);
         start    = 1'($urandom);
         if (i % 5 == 4) check_all("no_tick", 1'b0, 1'b0, 8'd1, IN_PIPE);
      end

      tick("pipe_hit",     1'b0, 4'd2, 16'hFC0F, 1'b0, 1'b1, 8'd1, DEAD);
      for (int i = 0; i < 4; i++)
         tick("dead_hold", 1'b1, 4'd5, 16'h0000, 1'b0, 1'b1, 8'd1, DEAD);

      // Floor collision from CLEAR
      do_reset();
      tick("start2",       1'b1, 4'd5,  16'h0000, 1'b0, 1'b0, 8'd0, CLEAR);
      tick("floor_clear",  1'b0, 4'd15, 16'h0000, 1'b0, 1'b1, 8'd0, DEAD);

      // Floor hit on the would-be exit tick: hit wins, no pass, no count
      do_reset();
      tick("start3",       1'b1, 4'd5,  16'h0000, 1'b0, 1'b0, 8'd0, CLEAR);
      tick("enter_pipe3",  1'b0, 4'd5,  16'h8001, 1'b0, 1'b0, 8'd0, IN_PIPE);
      tick("floor_exit",   1'b0, 4'd15, 16'h0000, 1'b0, 1'b1, 8'd0, DEAD);

      // Death while a pass is pending clears it on the same edge
      do_reset();
      tick("start4",       1'b1, 4'd5,  16'h0000, 1'b0, 1'b0, 8'd0, CLEAR);
      tick("enter_pipe4",  1'b0, 4'd5,  16'hFC0F, 1'b0, 1'b0, 8'd0, IN_PIPE);
      tick("exit4",        1'b0, 4'd5,  16'h0000, 1'b1, 1'b0, 8'd1, CLEAR);
      tick("die_pending",  1'b0, 4'd3,  16'h0008, 1'b0, 1'b1, 8'd1, DEAD);

      // Counter saturation
      do_reset();
      tick("start5",       1'b1, 4'd5,  16'h0000, 1'b0, 1'b0, 8'd0, CLEAR);
      for (int i = 1; i <= 260; i++) begin
         tick("sat_enter", 1'b0, 4'd5, 16'hFC0F, 1'b0, 1'b0, (i > 256) ? 8'd255 : 8'(i - 1), IN_PIPE);
         tick("sat_exit",  1'b0, 4'd5, 16'h0000, 1'b1, 1'b0, (i > 255) ? 8'd255 : 8'(i), CLEAR);
      end
      tick("sat_idle",     1'b0, 4'd5, 16'h0000, 1'b0, 1'b0, 8'd255, CLEAR);
      tick("sat_enter2",   1'b0, 4'd5, 16'hFC0F, 1'b0, 1'b0, 8'd255, IN_PIPE);
      tick("sat_exit2",    1'b0, 4'd5, 16'h0000, 1'b1, 1'b0, 8'd255, CLEAR);

      // Asynchronous reset while pass is high, away from any clk edge
      #2;
      reset = 1'b0;
      #1;
      check_all("async_rst", 1'b0, 1'b0, 8'd0, IDLE);
      @(negedge clk);
      check_all("rst_held", 1'b0, 1'b0, 8'd0, IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
